div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl_pkg.sv | 16 +
 rtl/div_ctrl.sv | 136 +++++++++++++
 tb/tb_div_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared defines for the M-extension divide controller: datapath width and
// the funct3 codes of the four divide/remainder instructions.
package div_ctrl_pkg;

    localparam int CPU_WIDTH = 32;

    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_REM  = 3'b110;
    localparam logic [2:0] OP_REMU = 3'b111;

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_ctrl.sv
// Sequences one divide at a time through an external iterative divider:
// latches the command, stalls EX, writes the result back, handles flush and hangs.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 48
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_i,
    input  logic [2:0]           op_i,
    input  logic [CPU_WIDTH-1:0] dividend_i,
    input  logic [CPU_WIDTH-1:0] divisor_i,
    input  logic [4:0]           rd_i,
    input  logic                 flush_i,
    output logic                 hold_o,
    output logic                 reg_we_o,
    output logic [4:0]           reg_waddr_o,
    output logic [CPU_WIDTH-1:0] reg_wdata_o,
    output logic                 div_start_o,
    output logic [2:0]           div_op_o,
    output logic [CPU_WIDTH-1:0] div_dividend_o,
    output logic [CPU_WIDTH-1:0] div_divisor_o,
    input  logic                 div_ready_i,
    input  logic                 div_busy_i,
    input  logic [CPU_WIDTH-1:0] div_result_i,
    output logic                 timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    localparam int               CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TMO   = CNT_W'(TIMEOUT_CYC);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [2:0]             op_q, op_d;
    logic [CPU_WIDTH-1:0]   dividend_q, dividend_d;
    logic [CPU_WIDTH-1:0]   divisor_q, divisor_d;
    logic [4:0]             rd_q, rd_d;
    logic                   we_q, we_d;
    logic [4:0]             waddr_q, waddr_d;
    logic [CPU_WIDTH-1:0]   wdata_q, wdata_d;
    logic                   timeout_q, timeout_d;
    logic                   accept;

    assign accept  = (state_q == S_IDLE) && req_i && is_div_op(op_i) && !flush_i;
    // Saturate at the threshold so the counter never wraps back under it.
    assign cnt_inc = (cnt_q == TMO) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        rd_d       = rd_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        timeout_d  = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d       = op_i;
                    dividend_d = dividend_i;
                    divisor_d  = divisor_i;
                    rd_d       = rd_i;
                    cnt_d      = '0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = cnt_inc;
                // Flush outranks a result arriving in the same cycle.
                if (flush_i) begin
                    state_d = S_DRAIN;
                end else if (div_ready_i) begin
                    we_d    = 1'b1;
                    waddr_d = rd_q;
                    wdata_d = div_result_i;
                    state_d = S_IDLE;
                end else if (cnt_inc >= TMO) begin
                    timeout_d = 1'b1;
                    state_d   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!div_busy_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            rd_q       <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            rd_q       <= rd_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            timeout_q  <= timeout_d;
        end
    end

    // Start drops combinationally with ready so the divider cannot relaunch.
    assign div_start_o    = (state_q == S_RUN) && !div_ready_i && !flush_i;
    assign hold_o         = accept || (state_q == S_RUN) || ((state_q == S_DRAIN) && req_i);
    assign div_op_o       = op_q;
    assign div_dividend_o = dividend_q;
    assign div_divisor_o  = divisor_q;
    assign reg_we_o       = we_q;
    assign reg_waddr_o    = waddr_q;
    assign reg_wdata_o    = wdata_q;
    assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: a stub iterative divider plus a
// reference model built from RISC-V M-extension division rules.
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    localparam int TMO = 48;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic [2:0]  op_i;
    logic [31:0] dividend_i, divisor_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic        hold_o, reg_we_o, div_start_o, timeout_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o, div_dividend_o, div_divisor_o;
    logic [2:0]  div_op_o;
    logic        div_ready_i, div_busy_i;
    logic [31:0] div_result_i;

    int errors = 0;
    int checks = 0;

    div_ctrl #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .op_i(op_i),
        .dividend_i(dividend_i), .divisor_i(divisor_i), .rd_i(rd_i),
        .flush_i(flush_i), .hold_o(hold_o), .reg_we_o(reg_we_o),
        .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
        .div_start_o(div_start_o), .div_op_o(div_op_o),
        .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
        .div_ready_i(div_ready_i), .div_busy_i(div_busy_i),
        .div_result_i(div_result_i), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // ---------------- stub divider (bit-serial, shared system reset) ----------------
    bit         hang = 1'b0;
    int         stub_cnt;
    logic [31:0] stub_res;

    function automatic void udivrem(input logic [31:0] n, input logic [31:0] d,
                                    output logic [31:0] q, output logic [31:0] r);
        logic [32:0] rem;
        rem = '0;
        q   = '0;
        for (int i = 31; i >= 0; i--) begin
            rem = {rem[31:0], n[i]};
            if (rem >= {1'b0, d}) begin
                rem  = rem - {1'b0, d};
                q[i] = 1'b1;
            end
        end
        r = rem[31:0];
    endfunction

    function automatic logic [31:0] stub_calc(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic        sgn;
        logic [31:0] na, nb, q, r;
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        sgn = !op[0];
        na  = (sgn && a[31]) ? -a : a;
        nb  = (sgn && b[31]) ? -b : b;
        udivrem(na, nb, q, r);
        if (sgn && (a[31] ^ b[31])) q = -q;
        if (sgn && a[31]) r = -r;
        return op[1] ? r : q;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            div_busy_i  <= 1'b0;
            div_ready_i <= 1'b0;
            stub_cnt    <= 0;
            stub_res    <= '0;
        end else begin
            div_ready_i <= 1'b0;
            if (div_busy_i) begin
                if (stub_cnt == 0) begin
                    div_busy_i  <= 1'b0;
                    div_ready_i <= !hang;
                end else begin
                    stub_cnt <= stub_cnt - 1;
                end
            end else if (div_start_o) begin
                div_busy_i <= 1'b1;
                stub_cnt   <= hang ? 60 : (div_divisor_o == 0 ? 0 : 33);
                stub_res   <= stub_calc(div_op_o, div_dividend_o, div_divisor_o);
            end
        end
    end
    assign div_result_i = stub_res;

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:  return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Write cycle relative to accept for the stub divider's latency.
    function automatic int ref_lat(input logic [31:0] b);
        return (b == 0) ? 4 : 37;
    endfunction

    // ---------------- transaction driver / monitor ----------------
    int          wc_q[$];
    logic [31:0] wd_q[$];
    logic [4:0]  wa_q[$];
    int          hold_last;
    int          to_c;

    task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input int flush_c, input int rst_c,
                           input bit hng, input bit chain, input logic [2:0] op2,
                           input logic [31:0] a2, input logic [31:0] b2, input logic [4:0] rd2,
                           input int ncyc);
        int lat1;
        lat1 = ref_lat(b);
        wc_q.delete(); wd_q.delete(); wa_q.delete();
        hold_last = -1;
        to_c = -1;
        @(posedge clk); #1;
        hang = hng;
        req_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; rd_i = rd;
        @(negedge clk);
        chk("accept_hold", {31'b0, hold_o}, 32'd1);
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            req_i = 1'b0;
            if (chain && c == lat1) begin
                req_i = 1'b1; op_i = op2; dividend_i = a2; divisor_i = b2; rd_i = rd2;
            end
            if (flush_c > 0 && c == flush_c + 2) begin
                req_i = 1'b1; op_i = OP_DIV;
            end
            flush_i = (c == flush_c);
            rst     = (c == rst_c);
            @(negedge clk);
            if (reg_we_o) begin
                wc_q.push_back(c); wd_q.push_back(reg_wdata_o); wa_q.push_back(reg_waddr_o);
            end
            if (hold_o) hold_last = c;
            if (timeout_o && to_c < 0) to_c = c;
            if (chain && c == lat1) chk("b2b_accept", {31'b0, hold_o}, 32'd1);
            if (c == rst_c + 1) begin
                chk("rst_mid_hold",  {31'b0, hold_o}, 32'd0);
                chk("rst_mid_start", {31'b0, div_start_o}, 32'd0);
                chk("rst_mid_we",    {31'b0, reg_we_o}, 32'd0);
                chk("rst_mid_tmo",   {31'b0, timeout_o}, 32'd0);
                chk("rst_mid_ops",   div_dividend_o | div_divisor_o | {29'b0, div_op_o}, 32'd0);
                chk("rst_mid_wb",    reg_wdata_o | {27'b0, reg_waddr_o}, 32'd0);
            end
        end
        @(posedge clk); #1;
        req_i = 1'b0; flush_i = 1'b0; rst = 1'b0; hang = 1'b0;
    endtask

    task automatic expect_one(input string tag, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] rd);
        chk({tag, "_nwr"}, wc_q.size(), 1);
        if (wc_q.size() >= 1) begin
            chk({tag, "_cyc"},   wc_q[0], ref_lat(b));
            chk({tag, "_addr"},  {27'b0, wa_q[0]}, {27'b0, rd});
            chk({tag, "_data"},  wd_q[0], ref_res(op, a, b));
        end
        chk({tag, "_hold"}, hold_last, ref_lat(b) - 1);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        logic [4:0]  rrd;
        int          ops[4];
        ops = '{OP_DIV, OP_DIVU, OP_REM, OP_REMU};

        rst = 1'b1; req_i = 1'b0; op_i = '0; dividend_i = '0; divisor_i = '0;
        rd_i = '0; flush_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hold",  {31'b0, hold_o}, 32'd0);
        chk("rst_we",    {31'b0, reg_we_o}, 32'd0);
        chk("rst_start", {31'b0, div_start_o}, 32'd0);
        chk("rst_tmo",   {31'b0, timeout_o}, 32'd0);
        chk("rst_regs",  reg_wdata_o | div_dividend_o | div_divisor_o |
                         {27'b0, reg_waddr_o} | {29'b0, div_op_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // DIVU 100/7 -> rd5 = 14 at cycle 37
        run_div(OP_DIVU, 100, 7, 5, -1, -1, 0, 0, 0, 0, 0, 0, 42);
        expect_one("divu", OP_DIVU, 100, 7, 5);
        chk("divu_val", wd_q.size() > 0 ? wd_q[0] : 32'hx, 32'd14);

        // DIV 0x80000000/0 -> -1 at cycle 4
        run_div(OP_DIV, 32'h8000_0000, 0, 3, -1, -1, 0, 0, 0, 0, 0, 0, 8);
        expect_one("divz", OP_DIV, 32'h8000_0000, 0, 3);

        // REM -7/2 then REMU 9/4 accepted in the write cycle
        run_div(OP_REM, -32'sd7, 2, 7, -1, -1, 0, 1, OP_REMU, 9, 4, 0, 80);
        chk("b2b_nwr", wc_q.size(), 2);
        if (wc_q.size() == 2) begin
            chk("b2b_d1", wd_q[0], 32'hFFFF_FFFF);
            chk("b2b_c2", wc_q[1], 74);
            chk("b2b_a2", {27'b0, wa_q[1]}, 32'd0);
            chk("b2b_d2", wd_q[1], 32'd1);
        end

        // Divider that never reports ready
        run_div(OP_DIV, 10, 3, 9, -1, -1, 1, 0, 0, 0, 0, 0, 70);
        chk("tmo_cyc",  to_c, TMO + 1);
        chk("tmo_nwr",  wc_q.size(), 0);
        chk("tmo_hold", hold_last, TMO);

        // Flush at cycle 10; req during DRAIN must stall but not be accepted
        run_div(OP_DIV, 50, 5, 4, 10, -1, 0, 0, 0, 0, 0, 0, 80);
        chk("flush_nwr",  wc_q.size(), 0);
        chk("flush_hold", hold_last, 12);
        chk("tmo_sticky", {31'b0, timeout_o}, 32'd1);
        run_div(OP_DIV, 50, 5, 4, -1, -1, 0, 0, 0, 0, 0, 0, 42);
        expect_one("post_flush", OP_DIV, 50, 5, 4);

        // Reset pulse at cycle 20 of a divide
        run_div(OP_DIVU, 1000, 9, 11, -1, 20, 0, 0, 0, 0, 0, 0, 50);
        chk("rst_nwr", wc_q.size(), 0);

        // Randomized divides, with occasional illegal-op requests
        for (int n = 0; n < 20; n++) begin
            rop = 3'(ops[$urandom_range(0, 3)]);
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0, 1: rb = 0;
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: rb = $urandom_range(1, 15);
                default: ;
            endcase
            rrd = 5'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
                req_i = 1'b1; op_i = 3'($urandom_range(0, 3));
                @(negedge clk);
                chk("bad_op_hold", {31'b0, hold_o}, 32'd0);
                @(posedge clk); #1;
                req_i = 1'b0;
                @(negedge clk);
                chk("bad_op_idle", {31'b0, hold_o | reg_we_o}, 32'd0);
            end
            run_div(rop, ra, rb, rrd, -1, -1, 0, 0, 0, 0, 0, 0, ref_lat(rb) + 3);
            expect_one("rand", rop, ra, rb, rrd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
